alu_responder: RTL and testbench
================================

# alu_responder

Sequential request/response front-end for the 10-bit signed ALU operation set (ADD, SUB, SHL, SHR, AND, ORR, XOR, XNOR). It accepts one operation through a valid/ready handshake and computes the result and four status flags, using a bit-serial shifter for SHL/SHR. It holds the response until the consumer takes it. It is the responder end of the same operand/opcode/result/flag interface that the ALU stimulus benches initiate, for use behind a register file or command sequencer.

## Interface
- `WIDTH`, 10, operand/result width in bits, two's complement.
- `SHW`, 4, width of the shift-amount field taken from `i_arg1[SHW-1:0]`.

Ports (clock and reset first):
- `i_clk`  in  1  the single clock; all state changes on its rising edge.
- `i_rst_n`  in  1  reset, synchronous and active-low.
- `i_valid`  in  1  request valid.
- `o_ready`  out  1  responder can accept a request.
- `i_arg0`  in  WIDTH  operand A, signed.
- `i_arg1`  in  WIDTH  operand B, signed; low SHW bits give the shift amount.
- `i_oper`  in  3  opcode: 0 ADD, 1 SUB, 2 SHL, 3 SHR, 4 AND, 5 ORR, 6 XOR, 7 XNOR.
- `o_valid`  out  1  response valid.
- `i_ready`  in  1  consumer accepts the response.
- `o_result`  out  WIDTH  result, signed.
- `o_flag`  out  4  flags: [0] Z zero, [1] N result sign, [2] V signed overflow, [3] C carry/borrow/last bit shifted out.

## Operation
- FSM states: IDLE, EXEC, DONE.
- `o_ready` is 1 only in IDLE. A request is accepted when `i_valid && o_ready`, and operands and opcode are registered on that edge.
- **Non-shift ops** are computed at the accept edge; next state is DONE.
- **ADD**: result = (A+B) mod 2^WIDTH.
  - C = carry out of the unsigned WIDTH-bit add.
  - V = operands share a sign and the result sign differs.
- **SUB**: result = (A−B) mod 2^WIDTH.
  - C = borrow, i.e. unsigned A < unsigned B.
  - V = operand signs differ and the result sign differs from A.
- **Logic ops**: bitwise on all bits; XNOR = ~(A^B). V=0, C=0.
- **Shift ops**: amount k = `i_arg1[SHW-1:0]`, clamped to WIDTH.
  - k=0: next state is DONE with result=A, C=0, V=0.
  - k>0: load the counter with k and go to EXEC.
  - In EXEC, each cycle shifts by one bit and decrements the counter. Go to DONE when the counter reaches 0.
  - SHL is logical: inserts 0. C = last bit shifted out. V is sticky: set if the sign bit changes at any step.
  - SHR is arithmetic: replicates the sign bit. C = last bit shifted out. V=0.
- Z and N are always derived from the final result.
- In DONE, `o_valid`=1 and `o_result`/`o_flag` are held stable. On `o_valid && i_ready`, go to IDLE.
- `i_arg*`/`i_oper` changes while not in IDLE are ignored.

## Timing
- Reset (`i_rst_n`=0 at a rising edge) forces:
  - state IDLE
  - `o_valid`=0, `o_ready`=1
  - `o_result`=0, `o_flag`=0
  - counter 0
- Reset applied mid-EXEC or in DONE discards the operation; no response is produced.
- Latency from the accept edge to `o_valid`=1:
  - non-shift ops and k=0 shifts: 1 cycle.
  - shifts with k>0: k+1 cycles.
  - The maximum is WIDTH+1 = 11.
- Responses are not combinationally bypassed. The earliest next accept is the cycle after the response handshake, so peak throughput is one operation per 2 cycles.
- Backpressure: `o_valid` stays high and the outputs stay frozen for any number of cycles with `i_ready`=0.
- `i_valid` held high across a busy period is accepted only on return to IDLE.

## Configuration
- `ALU_RESPONDER_BARREL_EN` **defined**:
  - SHL/SHR are computed by a single-cycle barrel shifter at the accept edge; EXEC and the counter are removed.
  - Shift latency is 1 cycle, and results and flags are identical to the serial version (C = last bit shifted out, SHL V = sign changed at any step).
- `ALU_RESPONDER_BARREL_EN` **undefined**: the bit-serial EXEC path is used, with the latency given in Timing.

## Test plan
- ADD, A=64, B=16, `i_ready`=1 -> `o_valid` 1 cycle after accept; result 80; `o_flag`=4'b0000; `o_ready` returns to 1 the cycle after the handshake.
- ADD, A=511, B=511 -> result −2 (10'h3FE); `o_flag`=4'b0110 (V, N).
- SUB, A=−511, B=511 -> result 2; `o_flag`=4'b0100 (V only, no borrow).
- SHL, A=64, B=4 -> result 0; `o_flag`=4'b1101 (C, V, Z).
  - Serial build: `o_valid` 5 cycles after accept.
  - With `ALU_RESPONDER_BARREL_EN`: 1 cycle.
- SHR, A=−200, B=2 -> result −50; `o_flag`=4'b0010.
  - Then SHR with A=−1, B=15 (clamped to 10) -> result −1, C=1, `o_flag`=4'b1010.
- Backpressure and reset: XOR A=10'h155, B=10'h0FF with `i_ready`=0 for 3 cycles.
  - Result 10'h1AA and flags stay held; `o_ready`=0 throughout.
  - Then start SHL with B=8 and assert `i_rst_n`=0 at the 3rd EXEC cycle -> next cycle `o_valid`=0, `o_ready`=1, outputs 0; no stale response afterwards.

Source files
------------

// File: rtl/alu_responder.sv
// Request/response front-end for the 10-bit signed ALU: one op per valid/ready handshake, response held until taken.
// Define ALU_RESPONDER_BARREL_EN to compute shifts in one cycle instead of the bit-serial EXEC path.
module alu_responder #(
    parameter int WIDTH = 10,
    parameter int SHW   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_arg0,
    input  logic [WIDTH-1:0] i_arg1,
    input  logic [2:0]       i_oper,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       o_flag
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    typedef enum logic [2:0] {OpAdd, OpSub, OpShl, OpShr, OpAnd, OpOrr, OpXor, OpXnor} oper_t;

    typedef struct packed {
        logic             carry;
        logic             signFlip;
        logic [WIDTH-1:0] value;
    } step_t;

    localparam logic [SHW-1:0] MaxShift = SHW'(WIDTH);

    // One bit of shift: SHL inserts 0 and reports a sign change, SHR replicates the sign bit.
    function automatic step_t shiftStep(input logic [WIDTH-1:0] value, input logic left);
        step_t s;
        if (left) begin
            s.carry    = value[WIDTH-1];
            s.value    = {value[WIDTH-2:0], 1'b0};
            s.signFlip = value[WIDTH-1] ^ value[WIDTH-2];
        end else begin
            s.carry    = value[0];
            s.value    = {value[WIDTH-1], value[WIDTH-1:1]};
            s.signFlip = 1'b0;
        end
        return s;
    endfunction

    state_t           state_q;
    logic             valid_q;
    logic             ready_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flag_q;

    oper_t            operIn;
    logic [SHW-1:0]   shiftAmt;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] result_d;
    logic [3:0]       flag_d;
    logic             carry_d;
    logic             ovf_d;
    logic             startExec;
`ifdef ALU_RESPONDER_BARREL_EN
    step_t            barrelStep;
`else
    logic [SHW-1:0]   cnt_q;
    logic             isLeft_q;
    step_t            execStep;

    assign execStep = shiftStep(result_q, isLeft_q);
`endif

    assign operIn   = oper_t'(i_oper);
    assign shiftAmt = (i_arg1[SHW-1:0] > MaxShift) ? MaxShift : i_arg1[SHW-1:0];

    always_comb begin
        sum       = '0;
        result_d  = '0;
        carry_d   = 1'b0;
        ovf_d     = 1'b0;
        startExec = 1'b0;
`ifdef ALU_RESPONDER_BARREL_EN
        barrelStep = '0;
`endif
        case (operIn)
            OpAdd: begin
                sum      = {1'b0, i_arg0} + {1'b0, i_arg1};
                result_d = sum[WIDTH-1:0];
                carry_d  = sum[WIDTH];
                ovf_d    = (i_arg0[WIDTH-1] == i_arg1[WIDTH-1]) && (result_d[WIDTH-1] != i_arg0[WIDTH-1]);
            end
            OpSub: begin
                result_d = i_arg0 - i_arg1;
                carry_d  = i_arg0 < i_arg1;
                ovf_d    = (i_arg0[WIDTH-1] != i_arg1[WIDTH-1]) && (result_d[WIDTH-1] != i_arg0[WIDTH-1]);
            end
            OpShl, OpShr: begin
                result_d = i_arg0;
`ifdef ALU_RESPONDER_BARREL_EN
                for (int i = 0; i < WIDTH; i++) begin
                    if (i < int'(shiftAmt)) begin
                        barrelStep = shiftStep(result_d, operIn == OpShl);
                        result_d   = barrelStep.value;
                        carry_d    = barrelStep.carry;
                        ovf_d      = ovf_d | barrelStep.signFlip;
                    end
                end
`else
                startExec = (shiftAmt != '0);
`endif
            end
            OpAnd:   result_d = i_arg0 & i_arg1;
            OpOrr:   result_d = i_arg0 | i_arg1;
            OpXor:   result_d = i_arg0 ^ i_arg1;
            OpXnor:  result_d = ~(i_arg0 ^ i_arg1);
            default: result_d = '0;
        endcase
        flag_d = {carry_d, ovf_d, result_d[WIDTH-1], result_d == '0};
    end

    // Serial shifts keep C and sticky V in flag_q while running; Z/N are filled in on the final step.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            result_q <= '0;
            flag_q   <= '0;
`ifndef ALU_RESPONDER_BARREL_EN
            cnt_q    <= '0;
            isLeft_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        result_q <= result_d;
                        ready_q  <= 1'b0;
`ifndef ALU_RESPONDER_BARREL_EN
                        cnt_q    <= shiftAmt;
                        isLeft_q <= (operIn == OpShl);
`endif
                        if (startExec) begin
                            state_q <= EXEC;
                            flag_q  <= '0;
                        end else begin
                            state_q <= DONE;
                            valid_q <= 1'b1;
                            flag_q  <= flag_d;
                        end
                    end
                end
`ifndef ALU_RESPONDER_BARREL_EN
                EXEC: begin
                    result_q <= execStep.value;
                    cnt_q    <= cnt_q - 1'b1;
                    flag_q   <= {execStep.carry, flag_q[2] | execStep.signFlip, 2'b00};
                    if (cnt_q == SHW'(1)) begin
                        state_q <= DONE;
                        valid_q <= 1'b1;
                        flag_q  <= {execStep.carry, flag_q[2] | execStep.signFlip,
                                    execStep.value[WIDTH-1], execStep.value == '0};
                    end
                end
`endif
                DONE: begin
                    if (i_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_flag   = flag_q;

endmodule

// File: tb/tb_alu_responder.sv
// Scoreboard bench for alu_responder: directed vectors push expectations, a negedge monitor checks responses.
// Shift latency expectations follow ALU_RESPONDER_BARREL_EN when it is defined.
module tb_alu_responder;

    localparam int W = 10;
`ifdef ALU_RESPONDER_BARREL_EN
    localparam bit Barrel = 1'b1;
`else
    localparam bit Barrel = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rstN = 1'b0;
    logic         iValid = 1'b0;
    logic         oReady;
    logic [W-1:0] arg0 = '0;
    logic [W-1:0] arg1 = '0;
    logic [2:0]   oper = '0;
    logic         oValid;
    logic         iReady = 1'b1;
    logic [W-1:0] oResult;
    logic [3:0]   oFlag;

    typedef struct {
        logic [W-1:0] result;
        logic [3:0]   flag;
        int           latency;
    } exp_t;

    exp_t sbQ[$];
    int   cycle = 0;
    int   acceptCycle = 0;
    int   errors = 0;
    int   checks = 0;
    int   staleCount = 0;
    bit   firstSeen = 1'b1;
    bit   readyCheckPending = 1'b0;

    alu_responder #(.WIDTH(W), .SHW(4)) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .i_valid (iValid),
        .o_ready (oReady),
        .i_arg0  (arg0),
        .i_arg1  (arg1),
        .i_oper  (oper),
        .o_valid (oValid),
        .i_ready (iReady),
        .o_result(oResult),
        .o_flag  (oFlag)
    );

    always #5 clk = ~clk;

    // Cycle count plus the cycle of the most recent accepted request, for latency measurement.
    always @(posedge clk) begin
        cycle++;
        if (rstN && iValid && oReady) acceptCycle = cycle;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    function automatic int shiftLat(input int k);
        return Barrel ? 1 : ((k == 0) ? 1 : k + 1);
    endfunction

    // Monitor: compares every cycle a response is presented, so held outputs are checked too.
    always @(negedge clk) begin
        if (rstN) begin
            if (readyCheckPending) begin
                checkOutput("readyAfterHandshake", oReady, 1);
                readyCheckPending = 1'b0;
            end
            if (oValid) begin
                if (sbQ.size() == 0) begin
                    staleCount++;
                end else begin
                    checkOutput("result", oResult, sbQ[0].result);
                    checkOutput("flag", oFlag, sbQ[0].flag);
                    checkOutput("readyWhileValid", oReady, 0);
                    if (firstSeen) begin
                        checkOutput("latency", cycle - acceptCycle + 1, sbQ[0].latency);
                        firstSeen = 1'b0;
                    end
                    if (iReady) begin
                        void'(sbQ.pop_front());
                        firstSeen = 1'b1;
                        readyCheckPending = 1'b1;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W-1:0] expResult, input logic [3:0] expFlag, input int expLatency);
        int   waited = 0;
        exp_t e;
        @(negedge clk);
        while (!oReady && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!oReady) begin
            checkOutput("acceptTimeout", oReady, 1);
        end else begin
            iValid = 1'b1;
            oper = op;
            arg0 = a;
            arg1 = b;
            e.result = expResult;
            e.flag = expFlag;
            e.latency = expLatency;
            sbQ.push_back(e);
            @(posedge clk);
            #1;
            iValid = 1'b0;
            arg0 = 10'h2AA;
            arg1 = 10'h133;
            oper = 3'd1;
        end
    endtask

    task automatic waitDrain();
        int waited = 0;
        while (sbQ.size() != 0 && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (sbQ.size() != 0) checkOutput("drainTimeout", sbQ.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetValid", oValid, 0);
        checkOutput("resetReady", oReady, 1);
        checkOutput("resetResult", oResult, 0);
        checkOutput("resetFlag", oFlag, 0);
        rstN = 1'b1;

        applyStimulus(3'd0, 10'd64, 10'd16, 10'h050, 4'b0000, 1);
        applyStimulus(3'd0, 10'h1FF, 10'h1FF, 10'h3FE, 4'b0110, 1);
        applyStimulus(3'd1, 10'h201, 10'h1FF, 10'h002, 4'b0100, 1);
        applyStimulus(3'd2, 10'd64, 10'd4, 10'h000, 4'b1101, shiftLat(4));
        applyStimulus(3'd3, 10'h338, 10'd2, 10'h3CE, 4'b0010, shiftLat(2));
        applyStimulus(3'd3, 10'h3FF, 10'd15, 10'h3FF, 4'b1010, shiftLat(10));
        applyStimulus(3'd4, 10'h155, 10'h0FF, 10'h055, 4'b0000, 1);
        applyStimulus(3'd5, 10'h200, 10'h001, 10'h201, 4'b0010, 1);
        applyStimulus(3'd7, 10'h155, 10'h0FF, 10'h255, 4'b0010, 1);
        applyStimulus(3'd1, 10'd5, 10'd7, 10'h3FE, 4'b1010, 1);
        applyStimulus(3'd0, 10'h3FF, 10'h001, 10'h000, 4'b1001, 1);
        applyStimulus(3'd2, 10'h155, 10'h000, 10'h155, 4'b0000, shiftLat(0));
        waitDrain();

        iReady = 1'b0;
        applyStimulus(3'd6, 10'h155, 10'h0FF, 10'h1AA, 4'b0000, 1);
        repeat (4) @(negedge clk);
        iReady = 1'b1;
        waitDrain();

        applyStimulus(3'd2, 10'h003, 10'd8, 10'h300, 4'b0110, shiftLat(8));
        @(posedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b0;
        sbQ.delete();
        firstSeen = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midExecResetValid", oValid, 0);
        checkOutput("midExecResetReady", oReady, 1);
        checkOutput("midExecResetResult", oResult, 0);
        checkOutput("midExecResetFlag", oFlag, 0);
        #1;
        rstN = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("staleResponses", staleCount, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
